// File: rtl/mem_dump_sequencer_if.sv
// Memory inspection port and dump stream between the dump sequencer
// (master) and the CS_RISC core plus downstream consumer (slave).
interface mem_dump_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  program_done;
  logic [DATA_WIDTH-1:0] fpga_value;
  logic                  address_mode;
  logic [ADDR_WIDTH-1:0] fpga_address;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic                  dump_done;
  logic                  restart;

  modport master (
    input  program_done, fpga_value, dump_ready, restart,
    output address_mode, fpga_address, dump_valid, dump_data, dump_addr, dump_done
  );

  modport slave (
    output program_done, fpga_value, dump_ready, restart,
    input  address_mode, fpga_address, dump_valid, dump_data, dump_addr, dump_done
  );
endinterface

// File: rtl/mem_dump_sequencer.sv
// Post-run memory dump sequencer: once the core halts it takes over the
// data-memory address mux, walks a descending word window and streams
// (address, data) pairs out on a valid/ready interface.
module mem_dump_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned START_ADDR   = 4092,
  parameter int unsigned STEP         = 4,
  parameter int unsigned WORD_COUNT   = 9,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_dump_sequencer_if.master bus
);
  localparam int unsigned IDX_W = $clog2(WORD_COUNT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [2:0]       lat;
  logic             handshake;

  // Downstream acceptance only counts while a word is actually presented.
  assign handshake = bus.dump_valid & bus.dump_ready;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      index            <= '0;
      lat              <= '0;
      bus.address_mode <= 1'b0;
      bus.fpga_address <= '0;
      bus.dump_valid   <= 1'b0;
      bus.dump_data    <= '0;
      bus.dump_addr    <= '0;
      bus.dump_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.program_done) begin
            state            <= WAIT;
            bus.address_mode <= 1'b1;
            bus.fpga_address <= ADDR_WIDTH'(START_ADDR);
            index            <= '0;
            lat              <= 3'(READ_LATENCY);
          end
        end
        WAIT: begin
          if (!bus.program_done) begin
            state            <= IDLE;
            bus.address_mode <= 1'b0;
            bus.dump_valid   <= 1'b0;
            bus.dump_done    <= 1'b0;
          end else begin
            lat <= lat - 3'd1;
            if (lat == 3'd1) begin
              bus.dump_data  <= bus.fpga_value;
              bus.dump_addr  <= bus.fpga_address;
              bus.dump_valid <= 1'b1;
              state          <= PRESENT;
            end
          end
        end
        PRESENT: begin
          // Abort wins over a same-edge handshake; that word is not delivered.
          if (!bus.program_done) begin
            state            <= IDLE;
            bus.address_mode <= 1'b0;
            bus.dump_valid   <= 1'b0;
            bus.dump_done    <= 1'b0;
          end else if (handshake) begin
            bus.dump_valid <= 1'b0;
            if (index == IDX_W'(WORD_COUNT - 1)) begin
              state         <= DONE;
              bus.dump_done <= 1'b1;
            end else begin
              bus.fpga_address <= bus.fpga_address - ADDR_WIDTH'(STEP);
              index            <= index + 1'b1;
              lat              <= 3'(READ_LATENCY);
              state            <= WAIT;
            end
          end
        end
        DONE: begin
          if (!bus.program_done) begin
            state            <= IDLE;
            bus.address_mode <= 1'b0;
            bus.dump_valid   <= 1'b0;
            bus.dump_done    <= 1'b0;
          end else if (bus.restart) begin
            state            <= IDLE;
            bus.address_mode <= 1'b0;
            bus.dump_done    <= 1'b0;
            bus.fpga_address <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
